// File: rtl/fir_chain_feeder.sv
// Head-of-chain driver for the FIR tile array: issues the run control word, streams taps
// into the tap chain and feeds samples into tile 0 under its ready handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a config request
// S_CFG   | control word pulse on cont_* (one cycle)
// S_LOAD  | accepting num tap beats and forwarding them to the tap chain
// S_RUN   | forwarding samples to tile 0 while tile_ready is high
// S_FLUSH | flush pulse issued; draining the tile pipeline for FLUSH_WAIT cycles
module fir_chain_feeder #(
   parameter int DATA_W     = 16,
   parameter int NUM_W      = 8,
   parameter int MODE_W     = 2,
   parameter int SHIFT_W    = 5,
   parameter int MAX_TAPS   = 64,
   parameter int FLUSH_WAIT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [NUM_W-1:0]   cfg_num,
   input  logic [MODE_W-1:0]  cfg_mode,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic               tap_s_valid,
   output logic               tap_s_ready,
   input  logic [DATA_W-1:0]  tap_s_data,
   input  logic               smp_s_valid,
   output logic               smp_s_ready,
   input  logic [DATA_W-1:0]  smp_s_data,
   input  logic               flush_req,
   input  logic               tile_ready,
   output logic               cont_valid,
   output logic               cont_flush,
   output logic [MODE_W-1:0]  cont_mode,
   output logic [SHIFT_W-1:0] cont_shift,
   output logic [NUM_W-1:0]   cont_num,
   output logic               tap_valid,
   output logic [DATA_W-1:0]  tap_data,
   output logic               smp_valid,
   output logic [DATA_W-1:0]  smp_data,
   output logic               psum_valid,
   output logic [DATA_W-1:0]  psum_data,
   output logic               busy
);

   localparam int                WAIT_W    = $clog2(FLUSH_WAIT + 1);
   localparam logic [NUM_W-1:0]  MAX_NUM   = NUM_W'(MAX_TAPS);
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(FLUSH_WAIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_CFG, S_LOAD, S_RUN, S_FLUSH} state_t;

   state_t               state, state_nxt;
   logic [NUM_W-1:0]     num_lat, num_nxt, tap_cnt, cnt_nxt, cnt_inc, num_clip;
   logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
   logic                 cfg_acc, tap_acc, smp_acc;
   logic                 cont_valid_nxt, cont_flush_nxt, tap_valid_nxt, smp_valid_nxt;
   logic [MODE_W-1:0]    cont_mode_nxt;
   logic [SHIFT_W-1:0]   cont_shift_nxt;
   logic [NUM_W-1:0]     cont_num_nxt;
   logic [DATA_W-1:0]    tap_data_nxt, smp_data_nxt;

   // flush_req wins over every handshake in the cycle it is raised
   assign cfg_ready   = (state == S_IDLE) && !flush_req && !rst;
   assign tap_s_ready = (state == S_LOAD) && !flush_req;
   assign smp_s_ready = (state == S_RUN) && tile_ready && !flush_req;
   assign busy        = (state != S_IDLE);
   assign psum_valid  = 1'b0;
   assign psum_data   = '0;

   assign cfg_acc  = cfg_valid && cfg_ready;
   assign tap_acc  = tap_s_valid && tap_s_ready;
   assign smp_acc  = smp_s_valid && smp_s_ready;
   assign num_clip = (cfg_num > MAX_NUM) ? MAX_NUM : cfg_num;
   assign cnt_inc  = tap_cnt + NUM_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         num_lat    <= '0;
         tap_cnt    <= '0;
         wait_cnt   <= '0;
         cont_valid <= 1'b0;
         cont_flush <= 1'b0;
         cont_mode  <= '0;
         cont_shift <= '0;
         cont_num   <= '0;
         tap_valid  <= 1'b0;
         tap_data   <= '0;
         smp_valid  <= 1'b0;
         smp_data   <= '0;
      end else begin
         state      <= state_nxt;
         num_lat    <= num_nxt;
         tap_cnt    <= cnt_nxt;
         wait_cnt   <= wait_nxt;
         cont_valid <= cont_valid_nxt;
         cont_flush <= cont_flush_nxt;
         cont_mode  <= cont_mode_nxt;
         cont_shift <= cont_shift_nxt;
         cont_num   <= cont_num_nxt;
         tap_valid  <= tap_valid_nxt;
         tap_data   <= tap_data_nxt;
         smp_valid  <= smp_valid_nxt;
         smp_data   <= smp_data_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      num_nxt        = num_lat;
      cnt_nxt        = tap_cnt;
      wait_nxt       = wait_cnt;
      cont_valid_nxt = 1'b0;
      cont_flush_nxt = 1'b0;
      cont_mode_nxt  = '0;
      cont_shift_nxt = '0;
      cont_num_nxt   = '0;
      tap_valid_nxt  = 1'b0;
      tap_data_nxt   = '0;
      smp_valid_nxt  = 1'b0;
      smp_data_nxt   = '0;
      if (flush_req) begin
         state_nxt      = S_FLUSH;
         wait_nxt       = WAIT_LOAD;
         cnt_nxt        = '0;
         cont_valid_nxt = 1'b1;
         cont_flush_nxt = 1'b1;
      end else begin
         unique case (state)
            S_IDLE: begin
               // control word is registered at accept so it is on the wire during S_CFG
               if (cfg_acc) begin
                  state_nxt      = S_CFG;
                  num_nxt        = num_clip;
                  cnt_nxt        = '0;
                  cont_valid_nxt = 1'b1;
                  cont_mode_nxt  = cfg_mode;
                  cont_shift_nxt = cfg_shift;
                  cont_num_nxt   = num_clip;
               end
            end
            S_CFG: state_nxt = (num_lat != '0) ? S_LOAD : S_RUN;
            S_LOAD: begin
               if (tap_acc) begin
                  tap_valid_nxt = 1'b1;
                  tap_data_nxt  = tap_s_data;
                  if (cnt_inc == num_lat) begin
                     state_nxt = S_RUN;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end
            end
            S_RUN: begin
               if (smp_acc) begin
                  smp_valid_nxt = 1'b1;
                  smp_data_nxt  = smp_s_data;
               end
            end
            S_FLUSH: begin
               if (wait_cnt == '0) state_nxt = S_IDLE;
               else                wait_nxt  = wait_cnt - 1'b1;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

endmodule
